// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine sharing the program ROM with the CPU: DMA owns the ROM in XFER and stalls the CPU via CPU_WAIT.
// Reads complete one cycle after issue (CPU_VALID / OAM_WE); a transfer keeps DMA_BUSY high for DMA_LEN+1 cycles.
module oam_dma_arbiter #(
   parameter int DMA_LEN = 160
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CPU_RE,
   input  logic [15:0] CPU_ADDR,
   output logic        CPU_WAIT,
   output logic        CPU_VALID,
   output logic [7:0]  CPU_DATA,
   input  logic        DMA_WE,
   input  logic [7:0]  DMA_SRC,
   output logic        DMA_BUSY,
   output logic        ROM_RE,
   output logic [15:0] ROM_ADDR,
   input  logic [7:0]  ROM_DATA,
   output logic        OAM_WE,
   output logic [7:0]  OAM_ADDR,
   output logic [7:0]  OAM_DATA
);
   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   state_t     state, state_nxt;
   logic [7:0] src, src_nxt;
   logic [7:0] idx, idx_nxt;
   logic       in_xfer;
   logic       oam_pend;
   logic [7:0] oam_idx;
   logic       cpu_vld;

   assign in_xfer = (state == XFER);

   // The in-flight DMA byte is dropped on reset, so oam_pend clears with the rest.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= IDLE;
         src      <= 8'd0;
         idx      <= 8'd0;
         oam_pend <= 1'b0;
         oam_idx  <= 8'd0;
         cpu_vld  <= 1'b0;
      end else begin
         state    <= state_nxt;
         src      <= src_nxt;
         idx      <= idx_nxt;
         oam_pend <= in_xfer;
         oam_idx  <= idx;
         cpu_vld  <= CPU_RE & ~in_xfer;
      end
   end

   always_comb begin
      state_nxt = state;
      src_nxt   = src;
      idx_nxt   = idx;
      ROM_RE    = CPU_RE;
      ROM_ADDR  = CPU_ADDR;
      CPU_WAIT  = 1'b0;
      case (state)
         IDLE: state_nxt = IDLE;
         XFER: begin
            ROM_RE   = 1'b1;
            ROM_ADDR = {src, idx};
            CPU_WAIT = CPU_RE;
            if (idx == LAST_IDX) state_nxt = DRAIN;
            else                 idx_nxt   = idx + 8'd1;
         end
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A start strobe in any state (re)starts the transfer from byte 0.
      if (DMA_WE) begin
         state_nxt = XFER;
         src_nxt   = DMA_SRC;
         idx_nxt   = 8'd0;
      end
   end

   assign DMA_BUSY  = (state != IDLE);
   assign CPU_VALID = cpu_vld;
   assign CPU_DATA  = ROM_DATA;
   assign OAM_WE    = oam_pend;
   assign OAM_ADDR  = oam_pend ? oam_idx  : 8'd0;
   assign OAM_DATA  = oam_pend ? ROM_DATA : 8'd0;

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 The block SHALL have parameter DMA_LEN, default 160, setting the number of bytes per DMA transfer (legal range 1..256).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  sole clock; all state changes on its rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- CPU_RE  in  1  CPU read request to the program ROM.
- CPU_ADDR  in  16  CPU read address.
- CPU_WAIT  out  1  CPU must hold its request; the read was not granted this cycle.
- CPU_VALID  out  1  CPU_DATA holds data for the read granted in the previous cycle.
- CPU_DATA  out  8  CPU read data.
- DMA_WE  in  1  one-cycle strobe: CPU wrote the DMA start register (0xFF46).
- DMA_SRC  in  8  byte written with DMA_WE: source address high byte.
- DMA_BUSY  out  1  a DMA transfer is in progress.
- ROM_RE  out  1  read enable to the shared program ROM.
- ROM_ADDR  out  16  address to the shared program ROM.
- ROM_DATA  in  8  ROM output; valid one cycle after the address is issued.
- OAM_WE  out  1  OAM write strobe.
- OAM_ADDR  out  8  OAM byte offset (0x00..DMA_LEN-1).
- OAM_DATA  out  8  OAM write data.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, XFER, DRAIN.
REQ-004 In IDLE, DMA_WE=1 SHALL latch DMA_SRC into src, clear idx to 0, and enter XFER on the next cycle.
REQ-005 In XFER, each cycle the block SHALL drive ROM_RE=1 and ROM_ADDR={src,idx}, then increment idx.
REQ-006 When XFER issues idx=DMA_LEN-1, the next state SHALL be DRAIN.
REQ-007 DRAIN SHALL last exactly one cycle and then return to IDLE.
REQ-008 Every DMA read issued in cycle N SHALL produce, in cycle N+1: OAM_WE=1, OAM_ADDR=idx of that read, OAM_DATA=ROM_DATA.
REQ-009 DMA_BUSY SHALL be 1 in XFER and DRAIN and 0 in IDLE; a transfer therefore holds DMA_BUSY for DMA_LEN+1 cycles.
REQ-010 When the state is not XFER, ROM_RE SHALL equal CPU_RE and ROM_ADDR SHALL equal CPU_ADDR; the CPU is granted and CPU_WAIT=0.
REQ-011 In XFER, CPU_WAIT SHALL equal CPU_RE, and CPU_ADDR SHALL NOT reach the ROM.
REQ-012 CPU_VALID SHALL be a registered copy of (CPU_RE and granted); CPU_DATA SHALL equal ROM_DATA whenever CPU_VALID=1, and is don't-care otherwise.
REQ-013 A DMA read and a CPU grant SHALL never occur in the same cycle, and OAM_WE SHALL never coincide with CPU_VALID.
REQ-014 In IDLE, if DMA_WE and CPU_RE are both 1, the CPU read SHALL be granted that cycle and the DMA SHALL start next cycle.
REQ-015 DMA_WE in XFER or DRAIN SHALL restart the transfer:
- latch the new src, set idx=0, enter (or stay in) XFER;
- the in-flight read of the old transfer still completes its OAM write in the following cycle.
REQ-016 src SHALL be used unmodified, including values 0xE0..0xFF.
REQ-017 idx SHALL be 8 bits wide and SHALL never exceed DMA_LEN-1; there is no wrap within a transfer.
REQ-018 Outside the cycle after a DMA read, the block SHALL drive OAM_WE=0, OAM_ADDR=0 and OAM_DATA=0.

Reset
REQ-019 RST_N=0 sampled at a rising CLK edge SHALL:
- force IDLE and clear src, idx and CPU_VALID;
- drive DMA_BUSY=0, OAM_WE=0 and CPU_WAIT=0 from the next cycle.
REQ-020 A reset during XFER SHALL abort the transfer; no OAM write SHALL occur after the reset edge, including the in-flight byte.
REQ-021 While RST_N=0, CPU requests SHALL still pass through to the ROM (REQ-010), but CPU_VALID SHALL stay 0.

Verification
REQ-022 Full transfer: ROM[0xC000+i]=i^0x5A; DMA_WE with DMA_SRC=0xC0 -> OAM_WE is high for 160 consecutive cycles starting 2 cycles after the strobe; OAM[i]=i^0x5A; DMA_BUSY is high for 161 cycles.
REQ-023 CPU contention: CPU_RE=1, CPU_ADDR=0x0150 held throughout the transfer -> CPU_WAIT is 1 for all 160 XFER cycles and 0 in DRAIN; CPU_VALID=1 in the cycle after DRAIN with CPU_DATA=ROM[0x0150].
REQ-024 Simultaneous start: DMA_WE=1 and CPU_RE=1 in IDLE -> the CPU is granted (CPU_WAIT=0, CPU_VALID next cycle); the first DMA ROM_ADDR is 0xC000 in the following cycle.
REQ-025 Restart: DMA_WE with DMA_SRC=0xC1 after 50 bytes of a 0xC0 transfer -> OAM[0..50] carry 0xC0-page data, then OAM[0..159] are rewritten from 0xC100..0xC19F; DMA_BUSY stays high continuously.
REQ-026 Reset mid-transfer: RST_N=0 for 1 cycle at idx=80 -> no OAM_WE after the reset edge; DMA_BUSY=0; the CPU is granted on the next CPU_RE.
REQ-027 Parameter: DMA_LEN=1 -> exactly one OAM write (OAM_ADDR=0) and DMA_BUSY high for 2 cycles.
